// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_framer
// Description : Assembles fixed-length multi-byte commands from a UART
//               receiver and queues response bytes to a UART transmitter.
//               RX side: bytes are consumed as soon as they are offered,
//               shifted MSB-first into an assembly register and handed to
//               the consumer as one command word. A completed command that
//               cannot be delivered is dropped and flagged (overrun). A
//               stalled partial command is discarded after TIMEOUT_CYCLES.
//               TX side: a small response FIFO feeds the transmitter, one
//               start strobe per byte, paced by the transmitter's done level.
// Ports       : clk, rst_n        clock, synchronous active-low reset
//               rx_rdy_i/rx_data_i/clr_rx_rdy_o   UART receiver handshake
//               cmd_rdy_o/cmd_o/clr_cmd_rdy_i     command to consumer
//               overrun_o/clr_overrun_i           sticky dropped-command flag
//               timeout_err_o                     partial-command discard pulse
//               resp_wr_i/resp_i/resp_full_o      response FIFO push side
//               trmt_o/tx_data_o/tx_done_i        UART transmitter handshake
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_framer #(
    parameter int CMD_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy_i,
    input  logic [7:0]             rx_data_i,
    output logic                   clr_rx_rdy_o,
    input  logic                   clr_cmd_rdy_i,
    output logic                   cmd_rdy_o,
    output logic [8*CMD_BYTES-1:0] cmd_o,
    output logic                   overrun_o,
    input  logic                   clr_overrun_i,
    output logic                   timeout_err_o,
    input  logic                   resp_wr_i,
    input  logic [7:0]             resp_i,
    output logic                   resp_full_o,
    output logic                   trmt_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_done_i
);

    localparam int CMD_W = 8 * CMD_BYTES;
    localparam int IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(CMD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT     = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(RESP_DEPTH);

    // RX state encoding
    localparam logic [0:0] RX_IDLE    = 1'b0;
    localparam logic [0:0] RX_COLLECT = 1'b1;

    // TX state encoding
    localparam logic [1:0] TX_IDLE   = 2'd0;
    localparam logic [1:0] TX_LAUNCH = 2'd1;
    localparam logic [1:0] TX_WAIT   = 2'd2;

    // ------------------------------------------------------------------
    // RX path registers
    // ------------------------------------------------------------------
    logic [0:0]       rx_state_q, rx_state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             overrun_q, overrun_d;
    logic             timeout_err_q, timeout_err_d;

    logic             w_byte;
    logic             w_last;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic             w_tmo_hit;
    logic [CMD_W-1:0] w_asm_next;

    assign w_byte     = rx_rdy_i;
    assign w_last     = (idx_q == IDX_LAST);
    assign w_complete = w_byte && w_last;
    // A completion is delivered if the consumer slot is free or is being
    // freed in this very cycle; otherwise the new command is lost.
    assign w_load     = w_complete && (!cmd_rdy_q || clr_cmd_rdy_i);
    assign w_drop     = w_complete && cmd_rdy_q && !clr_cmd_rdy_i;

    // The timeout fires on the idle cycle that brings the count to the limit.
    assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (rx_state_q == RX_COLLECT) &&
                        !rx_rdy_i && ((tmo_cnt_q + TMO_W'(1)) == TMO_LIMIT);

    // Assembly register only has to hold the earlier CMD_BYTES-1 bytes; the
    // final byte is merged straight from rx_data_i into the command word.
    // A timed-out partial needs no clearing: the next command shifts in
    // CMD_BYTES fresh bytes and overwrites every stale bit.
    generate
        if (CMD_BYTES == 1) begin : g_asm_single
            assign w_asm_next = rx_data_i;
        end else begin : g_asm_multi
            logic [CMD_W-9:0] asm_q;

            assign w_asm_next = {asm_q, rx_data_i};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    asm_q <= '0;
                end else if (w_byte) begin
                    asm_q <= w_asm_next[CMD_W-9:0];
                end
            end
        end
    endgenerate

    // RX FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    // RX FSM: next-state logic
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_byte && !w_last) begin
                    rx_state_d = RX_COLLECT;
                end
            end
            RX_COLLECT: begin
                if (w_complete || w_tmo_hit) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX FSM: outputs. The byte is taken in the cycle it is offered.
    always_comb begin
        clr_rx_rdy_o  = rx_rdy_i && rst_n;
        cmd_rdy_o     = cmd_rdy_q;
        cmd_o         = cmd_q;
        overrun_o     = overrun_q;
        timeout_err_o = timeout_err_q;
    end

    // RX datapath next-state
    always_comb begin
        idx_d         = idx_q;
        tmo_cnt_d     = '0;
        cmd_d         = cmd_q;
        cmd_rdy_d     = cmd_rdy_q;
        overrun_d     = overrun_q;
        timeout_err_d = w_tmo_hit;

        if (w_byte) begin
            idx_d = w_last ? '0 : (idx_q + IDX_W'(1));
        end else if (w_tmo_hit) begin
            idx_d = '0;
        end

        // Counter runs only between bytes of a partial command; any byte,
        // a timeout or leaving COLLECT returns it to zero.
        if ((TIMEOUT_CYCLES != 0) && (rx_state_q == RX_COLLECT) &&
            !w_byte && !w_tmo_hit) begin
            tmo_cnt_d = (tmo_cnt_q < TMO_LIMIT) ? (tmo_cnt_q + TMO_W'(1)) : tmo_cnt_q;
        end

        if (w_load) begin
            cmd_d     = w_asm_next;
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy_i) begin
            cmd_rdy_d = 1'b0;
        end

        // Setting beats clearing when both happen in one cycle.
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            tmo_cnt_q     <= '0;
            cmd_q         <= '0;
            cmd_rdy_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_q         <= cmd_d;
            cmd_rdy_q     <= cmd_rdy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [1:0]       tx_state_q, tx_state_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (fifo_cnt_q == '0);
    assign w_full  = (fifo_cnt_q == FIFO_FULL_CNT);
    // Fullness is judged on the registered count, so a pop in the same
    // cycle does not make room for a push.
    assign w_push  = resp_wr_i && !w_full;
    assign w_pop   = (tx_state_q == TX_IDLE) && !w_empty;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d   = w_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            mem_q[wr_ptr_q] <= resp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    // Next-state logic. TX_LAUNCH gives the transmitter one cycle to drop
    // tx_done after the start strobe, so a stale "done" is never trusted.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (!w_empty) begin
                    tx_state_d = TX_LAUNCH;
                end
            end
            TX_LAUNCH: tx_state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_done_i) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Outputs: strobe and head byte together; data bus is zero otherwise.
    always_comb begin
        trmt_o      = w_pop;
        tx_data_o   = w_pop ? mem_q[rd_ptr_q] : 8'h00;
        resp_full_o = w_full;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_framer
// Description : Directed testbench for uart_cmd_framer. Instance u_a uses
//               2-byte commands, a 10-cycle timeout and a 4-deep response
//               FIFO; instance u_b uses 3-byte commands. A per-cycle vector
//               table covers command assembly and handshakes, followed by
//               hand-written timeout, FIFO/transmit and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_framer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- instance A signals ----------------
    logic        a_rx_rdy, a_clr_rx_rdy, a_clr_cmd_rdy, a_cmd_rdy;
    logic [7:0]  a_rx_data;
    logic [15:0] a_cmd;
    logic        a_overrun, a_clr_overrun, a_timeout_err;
    logic        a_resp_wr, a_resp_full, a_trmt, a_tx_done;
    logic [7:0]  a_resp, a_tx_data;

    // ---------------- instance B signals ----------------
    logic        b_rx_rdy, b_clr_rx_rdy, b_clr_cmd_rdy, b_cmd_rdy;
    logic [7:0]  b_rx_data;
    logic [23:0] b_cmd;
    logic        b_overrun, b_clr_overrun, b_timeout_err;
    logic        b_resp_wr, b_resp_full, b_trmt, b_tx_done;
    logic [7:0]  b_resp, b_tx_data;

    uart_cmd_framer #(.CMD_BYTES(2), .TIMEOUT_CYCLES(10), .RESP_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .rx_rdy_i(a_rx_rdy), .rx_data_i(a_rx_data), .clr_rx_rdy_o(a_clr_rx_rdy),
        .clr_cmd_rdy_i(a_clr_cmd_rdy), .cmd_rdy_o(a_cmd_rdy), .cmd_o(a_cmd),
        .overrun_o(a_overrun), .clr_overrun_i(a_clr_overrun),
        .timeout_err_o(a_timeout_err),
        .resp_wr_i(a_resp_wr), .resp_i(a_resp), .resp_full_o(a_resp_full),
        .trmt_o(a_trmt), .tx_data_o(a_tx_data), .tx_done_i(a_tx_done)
    );

    uart_cmd_framer #(.CMD_BYTES(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rx_rdy_i(b_rx_rdy), .rx_data_i(b_rx_data), .clr_rx_rdy_o(b_clr_rx_rdy),
        .clr_cmd_rdy_i(b_clr_cmd_rdy), .cmd_rdy_o(b_cmd_rdy), .cmd_o(b_cmd),
        .overrun_o(b_overrun), .clr_overrun_i(b_clr_overrun),
        .timeout_err_o(b_timeout_err),
        .resp_wr_i(b_resp_wr), .resp_i(b_resp), .resp_full_o(b_resp_full),
        .trmt_o(b_trmt), .tx_data_o(b_tx_data), .tx_done_i(b_tx_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every transmit strobe seen on u_a, sampled mid-cycle.
    logic [7:0] tx_log[$];
    always @(negedge clk) begin
        if (a_trmt) tx_log.push_back(a_tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rx_rdy;
        logic [7:0]  rx_data;
        logic        clr_cmd;
        logic        clr_ovr;
        logic        e_clr_rx;
        logic        e_cmd_rdy;
        logic [15:0] e_cmd;
        logic        e_ovr;
        logic        e_terr;
    } vec_t;

    vec_t vt[19];

    task automatic send_b(input logic [7:0] d, input logic clr);
        b_rx_rdy      = 1'b1;
        b_rx_data     = d;
        b_clr_cmd_rdy = clr;
        @(negedge clk);
        check("b clr_rx_rdy strobe", {31'd0, b_clr_rx_rdy}, 32'd1);
        tick();
        b_rx_rdy      = 1'b0;
        b_clr_cmd_rdy = 1'b0;
    endtask

    initial begin : main
        int early;
        int late;

        // Each row is one clock cycle: inputs for the cycle, and the outputs
        // expected mid-cycle (clr_rx_rdy follows this row's inputs; the
        // registered outputs reflect the rows before).
        //          rdy data   clrC clrO | clrRx rdy cmd       ovr terr
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA53C, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA53C, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA53C, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA53C, 1'b0, 1'b0};
        vt[11] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0};
        vt[12] = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0};
        vt[13] = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        vt[14] = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0};
        vt[16] = '{1'b1, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0};
        vt[17] = '{1'b1, 8'hBC, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0};
        vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0};

        rst_n = 1'b0;
        a_rx_rdy = 0; a_rx_data = 0; a_clr_cmd_rdy = 0; a_clr_overrun = 0;
        a_resp_wr = 0; a_resp = 0; a_tx_done = 1'b1;
        b_rx_rdy = 0; b_rx_data = 0; b_clr_cmd_rdy = 0; b_clr_overrun = 0;
        b_resp_wr = 0; b_resp = 0; b_tx_done = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // ---------------- table-driven RX handshake ----------------
        for (int i = 0; i < 19; i++) begin
            a_rx_rdy      = vt[i].rx_rdy;
            a_rx_data     = vt[i].rx_data;
            a_clr_cmd_rdy = vt[i].clr_cmd;
            a_clr_overrun = vt[i].clr_ovr;
            @(negedge clk);
            check($sformatf("row%0d clr_rx_rdy", i), {31'd0, a_clr_rx_rdy}, {31'd0, vt[i].e_clr_rx});
            check($sformatf("row%0d cmd_rdy", i), {31'd0, a_cmd_rdy}, {31'd0, vt[i].e_cmd_rdy});
            check($sformatf("row%0d cmd", i), {16'd0, a_cmd}, {16'd0, vt[i].e_cmd});
            check($sformatf("row%0d overrun", i), {31'd0, a_overrun}, {31'd0, vt[i].e_ovr});
            check($sformatf("row%0d timeout_err", i), {31'd0, a_timeout_err}, {31'd0, vt[i].e_terr});
            tick();
        end
        a_rx_rdy = 0; a_clr_cmd_rdy = 0; a_clr_overrun = 0;
        check("initial tx idle", tx_log.size(), 0);

        // ---------------- timeout on a partial command ----------------
        a_clr_cmd_rdy = 1'b1; a_clr_overrun = 1'b1;
        tick();
        a_clr_cmd_rdy = 1'b0; a_clr_overrun = 1'b0;
        tick();
        a_rx_rdy = 1'b1; a_rx_data = 8'h55;
        tick();
        a_rx_rdy = 1'b0;
        early = 0;
        late  = 0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            early += int'(a_timeout_err);
            tick();
        end
        for (int j = 10; j <= 15; j++) begin
            @(negedge clk);
            late += int'(a_timeout_err);
            tick();
        end
        check("timeout premature pulse", early, 0);
        check("timeout pulse count", late, 1);
        @(negedge clk);
        check("timeout keeps cmd_rdy", {31'd0, a_cmd_rdy}, 32'd0);
        check("timeout keeps cmd", {16'd0, a_cmd}, 32'h5678);
        tick();
        a_rx_rdy = 1'b1; a_rx_data = 8'h12;
        tick();
        a_rx_data = 8'h34;
        tick();
        a_rx_rdy = 1'b0;
        @(negedge clk);
        check("post-timeout cmd", {16'd0, a_cmd}, 32'h1234);
        check("post-timeout cmd_rdy", {31'd0, a_cmd_rdy}, 32'd1);
        tick();

        // ---------------- response FIFO and transmit pacing ----------------
        a_tx_done = 1'b0;
        a_resp_wr = 1'b1; a_resp = 8'hEE;
        tick();
        a_resp_wr = 1'b0;
        repeat (3) tick();
        check("busy byte launched", tx_log.size(), 1);
        check("busy byte data", {24'd0, tx_log[0]}, 32'hEE);
        for (int k = 1; k <= 5; k++) begin
            a_resp_wr = 1'b1;
            a_resp    = 8'(k);
            @(negedge clk);
            check($sformatf("resp_full before push %0d", k), {31'd0, a_resp_full}, (k == 5) ? 32'd1 : 32'd0);
            tick();
        end
        a_resp_wr = 1'b0;
        @(negedge clk);
        check("resp_full after pushes", {31'd0, a_resp_full}, 32'd1);
        repeat (5) tick();
        check("no trmt without tx_done", tx_log.size(), 1);
        for (int i = 0; i < 4; i++) begin
            a_tx_done = 1'b1;
            tick();
            a_tx_done = 1'b0;
            repeat (4) tick();
            check($sformatf("tx count after release %0d", i), tx_log.size(), i + 2);
            check($sformatf("tx byte %0d", i), {24'd0, tx_log[i+1]}, i + 1);
            if (i == 0) begin
                @(negedge clk);
                check("resp_full after pop", {31'd0, a_resp_full}, 32'd0);
                tick();
            end
        end
        a_tx_done = 1'b1;
        repeat (5) tick();
        check("dropped byte never sent", tx_log.size(), 5);

        // ---------------- reset mid-command and mid-transmit ----------------
        a_tx_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_resp_wr = 1'b1;
            a_resp    = 8'hA1 + 8'(k);
            tick();
        end
        a_resp_wr = 1'b0;
        a_rx_rdy = 1'b1; a_rx_data = 8'hDE;
        tick();
        a_rx_rdy = 1'b0;
        @(negedge clk);
        check("pre-reset full", {31'd0, a_resp_full}, 32'd1);
        check("pre-reset launched", tx_log.size(), 6);
        tick();
        rst_n = 1'b0;
        a_rx_rdy = 1'b1; a_rx_data = 8'h77;
        @(negedge clk);
        check("clr_rx_rdy in reset", {31'd0, a_clr_rx_rdy}, 32'd0);
        tick();
        @(negedge clk);
        check("reset cmd_rdy", {31'd0, a_cmd_rdy}, 32'd0);
        check("reset cmd", {16'd0, a_cmd}, 32'd0);
        check("reset overrun", {31'd0, a_overrun}, 32'd0);
        check("reset timeout_err", {31'd0, a_timeout_err}, 32'd0);
        check("reset resp_full", {31'd0, a_resp_full}, 32'd0);
        check("reset trmt", {31'd0, a_trmt}, 32'd0);
        check("reset tx_data", {24'd0, a_tx_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        a_rx_rdy = 1'b0;
        a_tx_done = 1'b1;
        repeat (6) tick();
        check("no trmt after reset", tx_log.size(), 6);
        a_rx_rdy = 1'b1; a_rx_data = 8'h0F;
        tick();
        a_rx_data = 8'hF0;
        tick();
        a_rx_rdy = 1'b0;
        @(negedge clk);
        check("post-reset cmd", {16'd0, a_cmd}, 32'h0FF0);
        check("post-reset cmd_rdy", {31'd0, a_cmd_rdy}, 32'd1);
        tick();

        // ---------------- 3-byte commands and overrun ----------------
        send_b(8'hAA, 1'b0);
        send_b(8'hBB, 1'b0);
        send_b(8'hCC, 1'b0);
        @(negedge clk);
        check("b first cmd", {8'd0, b_cmd}, 32'hAABBCC);
        check("b first cmd_rdy", {31'd0, b_cmd_rdy}, 32'd1);
        tick();
        send_b(8'h11, 1'b0);
        send_b(8'h22, 1'b0);
        @(negedge clk);
        check("b partial keeps cmd", {8'd0, b_cmd}, 32'hAABBCC);
        tick();
        send_b(8'h33, 1'b0);
        @(negedge clk);
        check("b dropped cmd unchanged", {8'd0, b_cmd}, 32'hAABBCC);
        check("b overrun set", {31'd0, b_overrun}, 32'd1);
        check("b cmd_rdy held", {31'd0, b_cmd_rdy}, 32'd1);
        tick();
        send_b(8'h11, 1'b0);
        send_b(8'h22, 1'b0);
        send_b(8'h33, 1'b1);
        @(negedge clk);
        check("b cmd on clr cycle", {8'd0, b_cmd}, 32'h112233);
        check("b cmd_rdy stays", {31'd0, b_cmd_rdy}, 32'd1);
        check("b overrun unaffected", {31'd0, b_overrun}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
